vector_tile_buffer: RTL and testbench

Tile scratchpad directly downstream of the vector loader. Captures each TILE_WIDTH-bit tile the loader presents on its tile strobe and writes it into an on-chip buffer of DEPTH tile slots, starting at a caller-chosen base slot. Reports completion and tile count when the loader signals end of transfer. Provides a registered, one-tile-wide read port for the compute datapath (MVU/ALU stages).

---
 rtl/vector_tile_buffer_if.sv | 37 +++
 rtl/vector_tile_buffer.sv | 126 ++++++++++++
 tb/tb_vector_tile_buffer.sv | 250 +++++++++++++++++++++++++
 3 files changed

// File: rtl/vector_tile_buffer_if.sv
// Bus between the vector loader / compute datapath and the tile scratchpad.
// master = loader + reader side, slave = vector_tile_buffer.
interface vector_tile_buffer_if #(
    parameter int TILE_WIDTH = 256,
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 16
);
    localparam int ELEM_COUNT = TILE_WIDTH / DATA_WIDTH;
    localparam int AW         = $clog2(DEPTH);

    // Strobe semantics, no back-pressure: wr_start, tile_in, load_done and
    // rd_req are single-cycle qualifiers sampled on the rising edge; the buffer
    // always accepts them. wr_done and rd_valid are single-cycle pulses.
    logic                                     wr_start;
    logic [AW-1:0]                            wr_base;
    logic                                     tile_in;
    logic [0:ELEM_COUNT-1][DATA_WIDTH-1:0]    tile_data;
    logic                                     load_done;
    logic                                     busy;
    logic                                     wr_done;
    logic [AW:0]                              tile_count;
    logic                                     overflow;
    logic                                     rd_req;
    logic [AW-1:0]                            rd_addr;
    logic [0:ELEM_COUNT-1][DATA_WIDTH-1:0]    rd_data;
    logic                                     rd_valid;

    modport master (
        output wr_start, wr_base, tile_in, tile_data, load_done, rd_req, rd_addr,
        input  busy, wr_done, tile_count, overflow, rd_data, rd_valid
    );

    modport slave (
        input  wr_start, wr_base, tile_in, tile_data, load_done, rd_req, rd_addr,
        output busy, wr_done, tile_count, overflow, rd_data, rd_valid
    );
endinterface

// File: rtl/vector_tile_buffer.sv
// Tile scratchpad: captures loader tiles into DEPTH slots from a base slot,
// commits a tile count on end of transfer, and serves a registered read port.
module vector_tile_buffer #(
    parameter int TILE_WIDTH = 256,
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    vector_tile_buffer_if.slave  bus,
    output logic [1:0]           dbg_state
);
    localparam int ELEM_COUNT = TILE_WIDTH / DATA_WIDTH;
    localparam int AW         = $clog2(DEPTH);
    localparam logic [AW:0] CNT_FULL = (AW+1)'(DEPTH);

    typedef logic [0:ELEM_COUNT-1][DATA_WIDTH-1:0] tile_t;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_FILL   = 2'd1,
        ST_COMMIT = 2'd2
    } state_e;

    generate
        if (DATA_WIDTH != 8) begin : g_bad_data_width
            $fatal(1, "vector_tile_buffer: only DATA_WIDTH = 8 is supported");
        end
        if ((TILE_WIDTH % 8) != 0) begin : g_bad_tile_width
            $fatal(1, "vector_tile_buffer: TILE_WIDTH must be a multiple of 8");
        end
        if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
            $fatal(1, "vector_tile_buffer: DEPTH must be a power of two >= 2");
        end
    endgenerate

    state_e        state_q, state_d;
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW:0]   cnt_q, cnt_d;
    logic [AW:0]   tile_count_q, tile_count_d;
    logic          overflow_q, overflow_d;
    tile_t         mem_q [DEPTH];
    tile_t         mem_d [DEPTH];
    tile_t         rd_data_q, rd_data_d;
    logic          rd_valid_q, rd_valid_d;

    always_comb begin
        state_d      = state_q;
        wr_ptr_d     = wr_ptr_q;
        cnt_d        = cnt_q;
        tile_count_d = tile_count_q;
        overflow_d   = overflow_q;
        mem_d        = mem_q;

        // Read samples mem_q, so a same-slot write this cycle is not visible yet.
        rd_valid_d = bus.rd_req;
        rd_data_d  = bus.rd_req ? mem_q[bus.rd_addr] : rd_data_q;

        case (state_q)
            ST_IDLE: begin
                if (bus.wr_start) begin
                    wr_ptr_d   = bus.wr_base;
                    cnt_d      = '0;
                    overflow_d = 1'b0;
                    state_d    = ST_FILL;
                end
            end
            ST_FILL: begin
                if (bus.tile_in) begin
                    if (cnt_q < CNT_FULL) begin
                        mem_d[wr_ptr_q] = bus.tile_data;
                        wr_ptr_d        = wr_ptr_q + 1'b1;
                        cnt_d           = cnt_q + 1'b1;
                    end else begin
                        overflow_d = 1'b1;
                    end
                end
                // Count is latched on entry to COMMIT so it is valid alongside wr_done.
                if (bus.load_done) begin
                    tile_count_d = cnt_d;
                    state_d      = ST_COMMIT;
                end
            end
            ST_COMMIT: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            wr_ptr_q     <= '0;
            cnt_q        <= '0;
            tile_count_q <= '0;
            overflow_q   <= 1'b0;
            rd_data_q    <= '0;
            rd_valid_q   <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            state_q      <= state_d;
            wr_ptr_q     <= wr_ptr_d;
            cnt_q        <= cnt_d;
            tile_count_q <= tile_count_d;
            overflow_q   <= overflow_d;
            rd_data_q    <= rd_data_d;
            rd_valid_q   <= rd_valid_d;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= mem_d[i];
            end
        end
    end

    assign bus.busy       = (state_q != ST_IDLE);
    assign bus.wr_done    = (state_q == ST_COMMIT);
    assign bus.tile_count = tile_count_q;
    assign bus.overflow   = overflow_q;
    assign bus.rd_data    = rd_data_q;
    assign bus.rd_valid   = rd_valid_q;
    assign dbg_state      = state_q;
endmodule

// File: tb/tb_vector_tile_buffer.sv
// Directed + randomized bench for vector_tile_buffer with a slot-level reference model.
module tb_vector_tile_buffer;
  localparam int TILE_WIDTH = 256;
  localparam int DATA_WIDTH = 8;
  localparam int DEPTH      = 16;
  localparam int ELEM_COUNT = TILE_WIDTH / DATA_WIDTH;
  localparam int AW         = $clog2(DEPTH);

  typedef logic [0:ELEM_COUNT-1][DATA_WIDTH-1:0] tile_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [1:0] dbg_state;

  vector_tile_buffer_if #(.TILE_WIDTH(TILE_WIDTH), .DATA_WIDTH(DATA_WIDTH), .DEPTH(DEPTH)) bus();

  vector_tile_buffer #(.TILE_WIDTH(TILE_WIDTH), .DATA_WIDTH(DATA_WIDTH), .DEPTH(DEPTH)) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus.slave),
    .dbg_state (dbg_state)
  );

  always #5 clk = ~clk;

  int pass_cnt  = 0;
  int total_cnt = 0;

  // Reference model: slot contents plus last committed results.
  tile_t ref_mem [DEPTH];
  int    ref_count;
  bit    ref_overflow;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [TILE_WIDTH-1:0] obs, input logic [TILE_WIDTH-1:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else $error("FAIL %s: got %h expected %h", tag, obs, exp);
  endtask

  task automatic drive_idle();
    bus.wr_start  = 1'b0;
    bus.wr_base   = '0;
    bus.tile_in   = 1'b0;
    bus.tile_data = '0;
    bus.load_done = 1'b0;
    bus.rd_req    = 1'b0;
    bus.rd_addr   = '0;
  endtask

  task automatic model_reset();
    for (int i = 0; i < DEPTH; i++) ref_mem[i] = '0;
    ref_count    = 0;
    ref_overflow = 1'b0;
  endtask

  // Whole-vector model: the first DEPTH tiles land at consecutive slots modulo DEPTH.
  task automatic model_vector(input int base, input tile_t tiles[$]);
    for (int k = 0; k < tiles.size(); k++) begin
      if (k < DEPTH) ref_mem[(base + k) % DEPTH] = tiles[k];
    end
    ref_count    = (tiles.size() < DEPTH) ? tiles.size() : DEPTH;
    ref_overflow = (tiles.size() > DEPTH);
  endtask

  function automatic tile_t rand_tile();
    logic [TILE_WIDTH-1:0] v;
    for (int w = 0; w < TILE_WIDTH / 32; w++) v[w*32 +: 32] = $urandom();
    return tile_t'(v);
  endfunction

  function automatic tile_t pattern_tile(input int t);
    tile_t v;
    for (int i = 0; i < ELEM_COUNT; i++) v[i] = DATA_WIDTH'(16 * t + i);
    return v;
  endfunction

  task automatic send_tile(input tile_t data, input bit done);
    bus.tile_in   = 1'b1;
    bus.tile_data = data;
    bus.load_done = done;
    tick();
    bus.tile_in   = 1'b0;
    bus.load_done = 1'b0;
  endtask

  task automatic read_chk(input int addr, input string tag);
    bus.rd_req  = 1'b1;
    bus.rd_addr = AW'(addr);
    tick();
    bus.rd_req = 1'b0;
    chk($sformatf("%s rd_valid slot %0d", tag, addr), TILE_WIDTH'(bus.rd_valid), 1);
    chk($sformatf("%s rd_data slot %0d", tag, addr), bus.rd_data, ref_mem[addr]);
    tick();
    chk($sformatf("%s rd_valid drop slot %0d", tag, addr), TILE_WIDTH'(bus.rd_valid), 0);
    chk($sformatf("%s rd_data hold slot %0d", tag, addr), bus.rd_data, ref_mem[addr]);
  endtask

  // Full vector: start, tiles, load_done (coincident with last tile or separate), commit checks.
  task automatic run_vector(input int base, input tile_t tiles[$], input bit coincident, input string tag);
    bus.wr_start = 1'b1;
    bus.wr_base  = AW'(base);
    tick();
    bus.wr_start = 1'b0;
    chk({tag, " busy in fill"}, TILE_WIDTH'(bus.busy), 1);
    chk({tag, " overflow cleared"}, TILE_WIDTH'(bus.overflow), 0);
    for (int k = 0; k < tiles.size(); k++) begin
      send_tile(tiles[k], coincident && (k == tiles.size() - 1));
    end
    if (!coincident || tiles.size() == 0) begin
      bus.load_done = 1'b1;
      tick();
      bus.load_done = 1'b0;
    end
    model_vector(base, tiles);
    chk({tag, " wr_done"}, TILE_WIDTH'(bus.wr_done), 1);
    chk({tag, " busy in commit"}, TILE_WIDTH'(bus.busy), 1);
    chk({tag, " tile_count"}, TILE_WIDTH'(bus.tile_count), TILE_WIDTH'(ref_count));
    chk({tag, " overflow"}, TILE_WIDTH'(bus.overflow), TILE_WIDTH'(ref_overflow));
    tick();
    chk({tag, " wr_done pulse"}, TILE_WIDTH'(bus.wr_done), 0);
    chk({tag, " busy idle"}, TILE_WIDTH'(bus.busy), 0);
    chk({tag, " tile_count held"}, TILE_WIDTH'(bus.tile_count), TILE_WIDTH'(ref_count));
  endtask

  initial begin
    tile_t tiles[$];
    tile_t old;
    tile_t ta;
    tile_t tb_t;
    int    base;

    // Reset state
    drive_idle();
    model_reset();
    rst = 1'b1;
    repeat (3) tick();
    chk("reset busy", TILE_WIDTH'(bus.busy), 0);
    chk("reset wr_done", TILE_WIDTH'(bus.wr_done), 0);
    chk("reset tile_count", TILE_WIDTH'(bus.tile_count), 0);
    chk("reset overflow", TILE_WIDTH'(bus.overflow), 0);
    chk("reset rd_data", bus.rd_data, '0);
    chk("reset rd_valid", TILE_WIDTH'(bus.rd_valid), 0);
    rst = 1'b0;
    tick();
    read_chk(5, "reset");

    // Basic fill, load_done coincident with the third tile
    tiles = {};
    for (int t = 0; t < 3; t++) tiles.push_back(pattern_tile(t));
    run_vector(2, tiles, 1'b1, "basic");
    for (int s = 2; s <= 5; s++) read_chk(s, "basic");

    // Overflow: 18 tiles into 16 slots
    tiles = {};
    for (int t = 0; t < 18; t++) tiles.push_back(rand_tile());
    run_vector(0, tiles, 1'b0, "ovf");
    chk("ovf sticky", TILE_WIDTH'(bus.overflow), 1);
    for (int s = 0; s < DEPTH; s++) read_chk(s, "ovf");

    // Wrap-around from slot 14; slot 13 must keep its overflow-run contents
    tiles = {};
    for (int t = 0; t < 4; t++) tiles.push_back(rand_tile());
    run_vector(14, tiles, 1'b0, "wrap");
    for (int s = 13; s < 18; s++) read_chk(s % DEPTH, "wrap");

    // Same-slot read during write returns old data; wr_start during FILL is ignored
    ta   = rand_tile();
    tb_t = rand_tile();
    old  = ref_mem[7];
    bus.wr_start = 1'b1;
    bus.wr_base  = AW'(7);
    tick();
    bus.wr_start = 1'b0;
    bus.rd_req   = 1'b1;
    bus.rd_addr  = AW'(7);
    send_tile(ta, 1'b0);
    bus.rd_req = 1'b0;
    chk("rbw rd_valid", TILE_WIDTH'(bus.rd_valid), 1);
    chk("rbw old data", bus.rd_data, old);
    bus.wr_start = 1'b1;
    bus.wr_base  = AW'(3);
    send_tile(tb_t, 1'b0);
    bus.wr_start = 1'b0;
    bus.load_done = 1'b1;
    tick();
    bus.load_done = 1'b0;
    tiles = {ta, tb_t};
    model_vector(7, tiles);
    chk("edge wr_done", TILE_WIDTH'(bus.wr_done), 1);
    chk("edge tile_count", TILE_WIDTH'(bus.tile_count), TILE_WIDTH'(ref_count));
    tick();
    read_chk(7, "edge");
    read_chk(8, "edge");
    read_chk(3, "edge");

    // Zero-tile vector, minimum start-to-done latency
    tiles = {};
    run_vector(9, tiles, 1'b0, "zero");

    // Randomized vectors with random reads
    for (int v = 0; v < 5; v++) begin
      tiles = {};
      base  = $urandom_range(0, DEPTH - 1);
      for (int t = 0; t < $urandom_range(0, 6); t++) tiles.push_back(rand_tile());
      run_vector(base, tiles, 1'($urandom_range(0, 1)), $sformatf("rand%0d", v));
      for (int r = 0; r < 3; r++) read_chk($urandom_range(0, DEPTH - 1), $sformatf("rand%0d", v));
    end

    // Reset mid-FILL: partial vector discarded, memory cleared
    bus.wr_start = 1'b1;
    bus.wr_base  = AW'(0);
    tick();
    bus.wr_start = 1'b0;
    send_tile(rand_tile(), 1'b0);
    send_tile(rand_tile(), 1'b0);
    #2 rst = 1'b1;
    #1;
    chk("midrst busy", TILE_WIDTH'(bus.busy), 0);
    chk("midrst wr_done", TILE_WIDTH'(bus.wr_done), 0);
    chk("midrst tile_count", TILE_WIDTH'(bus.tile_count), 0);
    chk("midrst rd_data", bus.rd_data, '0);
    model_reset();
    tick();
    rst = 1'b0;
    for (int c = 0; c < 4; c++) begin
      tick();
      chk($sformatf("midrst no wr_done %0d", c), TILE_WIDTH'(bus.wr_done), 0);
    end
    for (int s = 0; s < DEPTH; s++) read_chk(s, "midrst");

    tiles = {};
    for (int t = 0; t < 3; t++) tiles.push_back(pattern_tile(t));
    run_vector(2, tiles, 1'b1, "refill");
    for (int s = 1; s <= 5; s++) read_chk(s, "refill");

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule
